// File: rtl/id_stage_pkg.sv
// Shared RV32I types for the decode stage: opcodes, ALU/compare ops, mux selects, control word.
package rv32i_types;

   typedef logic [31:0] rv32i_word;
   typedef logic [4:0]  rv32i_reg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   // sra/sub sit in the slt/sltu funct3 slots; those ops use the comparator instead
   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef enum logic [2:0] {
      beq  = 3'b000,
      bne  = 3'b001,
      blt  = 3'b100,
      bge  = 3'b101,
      bltu = 3'b110,
      bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic {alumux1_rs1, alumux1_pc} alumux1_sel_t;

   typedef enum logic [2:0] {
      alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2
   } alumux2_sel_t;

   typedef enum logic {cmpmux_rs2, cmpmux_i_imm} cmpmux_sel_t;

   typedef enum logic [3:0] {
      rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
   } regfilemux_sel_t;

   typedef enum logic [1:0] {pc_plus4, pc_alu_out, pc_alu_mod2, pc_branch} pcmux_sel_t;

   typedef struct packed {
      rv32i_opcode     opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      alu_ops          aluop;
      alumux1_sel_t    alumux1_sel;
      alumux2_sel_t    alumux2_sel;
      branch_funct3_t  cmpop;
      cmpmux_sel_t     cmpmux_sel;
      regfilemux_sel_t regfilemux_sel;
      logic            load_regfile;
      logic            mem_read;
      logic            mem_write;
      pcmux_sel_t      pcmux_sel;
   } rv32i_control_word;

   function automatic logic compare(input branch_funct3_t op, input rv32i_word a,
                                    input rv32i_word b);
      case (op)
         beq:     return a == b;
         bne:     return a != b;
         blt:     return $signed(a) < $signed(b);
         bge:     return $signed(a) >= $signed(b);
         bltu:    return a < b;
         bgeu:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID instruction and WB write port in, decoded fields and operands out.
interface id_stage_if #(
   parameter int unsigned width = 32
);
   import rv32i_types::*;

   logic [width-1:0]  ID_instr_i;
   logic [width-1:0]  ID_pc_out_i;
   logic              ID_load_regfile_i;
   logic [4:0]        ID_rd_wr_i;
   logic [width-1:0]  ID_wr_data_i;
   rv32i_control_word ID_ctrl_word_o;
   logic [width-1:0]  ID_instr_o;
   logic [width-1:0]  ID_pc_out_o;
   logic [width-1:0]  ID_rs1_out_o;
   logic [width-1:0]  ID_rs2_out_o;
   logic [width-1:0]  ID_i_imm_o;
   logic [width-1:0]  ID_s_imm_o;
   logic [width-1:0]  ID_b_imm_o;
   logic [width-1:0]  ID_u_imm_o;
   logic [width-1:0]  ID_j_imm_o;
   logic [4:0]        ID_rd_o;
   logic              ID_br_en_o;

   modport master (
      output ID_instr_i, ID_pc_out_i, ID_load_regfile_i, ID_rd_wr_i, ID_wr_data_i,
      input  ID_ctrl_word_o, ID_instr_o, ID_pc_out_o, ID_rs1_out_o, ID_rs2_out_o,
      input  ID_i_imm_o, ID_s_imm_o, ID_b_imm_o, ID_u_imm_o, ID_j_imm_o, ID_rd_o, ID_br_en_o
   );

   modport slave (
      input  ID_instr_i, ID_pc_out_i, ID_load_regfile_i, ID_rd_wr_i, ID_wr_data_i,
      output ID_ctrl_word_o, ID_instr_o, ID_pc_out_o, ID_rs1_out_o, ID_rs2_out_o,
      output ID_i_imm_o, ID_s_imm_o, ID_b_imm_o, ID_u_imm_o, ID_j_imm_o, ID_rd_o, ID_br_en_o
   );

endinterface

// File: rtl/id_stage_regfile.sv
// 32 x 32 register file, x0 hardwired to zero, async active-low clear.
// Define ID_REGFILE_BYPASS_EN to forward the pending write to same-cycle reads.
module regfile
   import rv32i_types::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load_i,
   input  rv32i_reg  rd_i,
   input  rv32i_word wr_data_i,
   input  rv32i_reg  rs1_i,
   input  rv32i_reg  rs2_i,
   output rv32i_word rs1_out_o,
   output rv32i_word rs2_out_o
);

   rv32i_word regs_q [32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (load_i && (rd_i != '0)) begin
         regs_q[rd_i] <= wr_data_i;
      end
   end

`ifdef ID_REGFILE_BYPASS_EN
   logic wr_fwd;

   // No forwarding while held in reset so operands stay zero
   assign wr_fwd = load_i && (rd_i != '0) && rst;

   assign rs1_out_o = (rs1_i == '0)                  ? '0        :
                      (wr_fwd && (rs1_i == rd_i))    ? wr_data_i : regs_q[rs1_i];
   assign rs2_out_o = (rs2_i == '0)                  ? '0        :
                      (wr_fwd && (rs2_i == rd_i))    ? wr_data_i : regs_q[rs2_i];
`else
   assign rs1_out_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
   assign rs2_out_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];
`endif

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: combinational decode, immediates and compare around the regfile.
// Write-to-read forwarding is selected by ID_REGFILE_BYPASS_EN (see regfile).
module id_stage
   import rv32i_types::*;
#(
   parameter int unsigned width = 32
) (
   input logic       clk,
   input logic       rst,
   id_stage_if.slave bus
);

   logic [width-1:0]  instr;
   rv32i_opcode       opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [width-1:0]  i_imm, s_imm, b_imm, u_imm, j_imm;
   logic [width-1:0]  rs1_out, rs2_out, cmp_b;
   rv32i_control_word ctrl;
   logic              cmp_en;

   assign instr  = bus.ID_instr_i;
   assign opcode = rv32i_opcode'(instr[6:0]);
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign i_imm = {{21{instr[31]}}, instr[30:20]};
   assign s_imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
   assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign u_imm = {instr[31:12], 12'h000};
   assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .load_i    (bus.ID_load_regfile_i),
      .rd_i      (bus.ID_rd_wr_i),
      .wr_data_i (bus.ID_wr_data_i),
      .rs1_i     (instr[19:15]),
      .rs2_i     (instr[24:20]),
      .rs1_out_o (rs1_out),
      .rs2_out_o (rs2_out)
   );

   always_comb begin
      ctrl        = '0;
      cmp_en      = 1'b0;
      ctrl.opcode = opcode;
      ctrl.funct3 = funct3;
      ctrl.funct7 = funct7;
      case (opcode)
         op_lui: begin
            ctrl.load_regfile   = 1'b1;
            ctrl.regfilemux_sel = rf_u_imm;
         end
         op_auipc: begin
            ctrl.alumux1_sel  = alumux1_pc;
            ctrl.alumux2_sel  = alumux2_u_imm;
            ctrl.load_regfile = 1'b1;
         end
         op_jal: begin
            ctrl.alumux1_sel    = alumux1_pc;
            ctrl.alumux2_sel    = alumux2_j_imm;
            ctrl.load_regfile   = 1'b1;
            ctrl.regfilemux_sel = rf_pc_plus4;
            ctrl.pcmux_sel      = pc_alu_out;
         end
         op_jalr: begin
            ctrl.load_regfile   = 1'b1;
            ctrl.regfilemux_sel = rf_pc_plus4;
            ctrl.pcmux_sel      = pc_alu_mod2;
         end
         op_br: begin
            ctrl.alumux1_sel = alumux1_pc;
            ctrl.alumux2_sel = alumux2_b_imm;
            ctrl.cmpop       = branch_funct3_t'(funct3);
            ctrl.pcmux_sel   = pc_branch;
            cmp_en           = 1'b1;
         end
         op_load: begin
            ctrl.mem_read     = 1'b1;
            ctrl.load_regfile = 1'b1;
            case (funct3)
               3'd0:    ctrl.regfilemux_sel = rf_lb;
               3'd1:    ctrl.regfilemux_sel = rf_lh;
               3'd4:    ctrl.regfilemux_sel = rf_lbu;
               3'd5:    ctrl.regfilemux_sel = rf_lhu;
               default: ctrl.regfilemux_sel = rf_lw;
            endcase
         end
         op_store: begin
            ctrl.alumux2_sel = alumux2_s_imm;
            ctrl.mem_write   = 1'b1;
         end
         op_imm, op_reg: begin
            ctrl.load_regfile = 1'b1;
            if (opcode == op_reg) begin
               ctrl.alumux2_sel = alumux2_rs2;
            end else begin
               ctrl.cmpmux_sel = cmpmux_i_imm;
            end
            case (funct3)
               3'd0: ctrl.aluop = (opcode == op_reg && funct7[5]) ? alu_sub : alu_add;
               3'd2: begin
                  ctrl.cmpop          = blt;
                  ctrl.regfilemux_sel = rf_br_en;
                  cmp_en              = 1'b1;
               end
               3'd3: begin
                  ctrl.cmpop          = bltu;
                  ctrl.regfilemux_sel = rf_br_en;
                  cmp_en              = 1'b1;
               end
               3'd5:    ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
               default: ctrl.aluop = alu_ops'(funct3);
            endcase
         end
         default: ctrl = '0;
      endcase
      if (instr[11:7] == 5'd0) begin
         ctrl.load_regfile = 1'b0;
      end
   end

   assign cmp_b = (ctrl.cmpmux_sel == cmpmux_i_imm) ? i_imm : rs2_out;

   assign bus.ID_ctrl_word_o = ctrl;
   assign bus.ID_instr_o     = instr;
   assign bus.ID_pc_out_o    = bus.ID_pc_out_i;
   assign bus.ID_rs1_out_o   = rs1_out;
   assign bus.ID_rs2_out_o   = rs2_out;
   assign bus.ID_i_imm_o     = i_imm;
   assign bus.ID_s_imm_o     = s_imm;
   assign bus.ID_b_imm_o     = b_imm;
   assign bus.ID_u_imm_o     = u_imm;
   assign bus.ID_j_imm_o     = j_imm;
   assign bus.ID_rd_o        = instr[11:7];
   assign bus.ID_br_en_o     = cmp_en & compare(ctrl.cmpop, rs1_out, cmp_b);

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage; expectations follow ID_REGFILE_BYPASS_EN when defined.
module tb_id_stage;
   import rv32i_types::*;

`ifdef ID_REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] mdl [32];
   logic [6:0]  ops [9];

   id_stage_if u_if ();

   id_stage #(.width(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic ld,
                        input logic [4:0] rd, input logic [31:0] d);
      u_if.ID_instr_i        = instr;
      u_if.ID_pc_out_i       = pc;
      u_if.ID_load_regfile_i = ld;
      u_if.ID_rd_wr_i        = rd;
      u_if.ID_wr_data_i      = d;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd, input logic [2:0] f3,
                                         input logic [6:0] f7);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   // Sign-extend the low 'bits' bits of v
   function automatic logic [31:0] sx(input logic [31:0] v, input int unsigned bits);
      logic [31:0] t;
      t = v << (32 - bits);
      return $signed(t) >>> (32 - bits);
   endfunction

   function automatic logic [31:0] exp_i(input logic [31:0] v);
      return sx(v >> 20, 12);
   endfunction
   function automatic logic [31:0] exp_s(input logic [31:0] v);
      return sx(((v >> 25) << 5) | ((v >> 7) & 31), 12);
   endfunction
   function automatic logic [31:0] exp_b(input logic [31:0] v);
      return sx((((v >> 31) & 1) << 12) | (((v >> 7) & 1) << 11) | (((v >> 25) & 63) << 5)
                | (((v >> 8) & 15) << 1), 13);
   endfunction
   function automatic logic [31:0] exp_j(input logic [31:0] v);
      return sx((((v >> 31) & 1) << 20) | (((v >> 12) & 255) << 12) | (((v >> 20) & 1) << 11)
                | (((v >> 21) & 1023) << 1), 21);
   endfunction

   function automatic logic [31:0] exp_reg(input logic [4:0] idx, input logic ld,
                                           input logic [4:0] rdw, input logic [31:0] d);
      if (idx == 0) return 32'h0;
      if (Bypass && ld && rdw == idx) return d;
      return mdl[idx];
   endfunction

   function automatic logic exp_br(input logic [31:0] v, input logic [31:0] a,
                                   input logic [31:0] b);
      logic [31:0] y;
      y = (v[6:0] == 7'h13) ? exp_i(v) : b;
      if (v[6:0] == 7'h63) begin
         case (v[14:12])
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
         endcase
      end
      if ((v[6:0] == 7'h13 || v[6:0] == 7'h33) && v[14:12] == 3'd2) return $signed(a) < $signed(y);
      if ((v[6:0] == 7'h13 || v[6:0] == 7'h33) && v[14:12] == 3'd3) return a < y;
      return 1'b0;
   endfunction

   function automatic logic exp_ld(input logic [31:0] v);
      logic writes;
      writes = v[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
      return writes && (v[11:7] != 5'd0);
   endfunction

   initial begin
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      drive(32'h13, 32'h0, 1'b0, 5'd0, 32'h0);
      #2 rst = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1;

      // Every register reads zero after reset
      for (int r = 1; r < 32; r++) begin
         drive(rtype(5'(r), 5'(r), 5'd1, 3'd0, 7'd0), 32'h0, 1'b0, 5'd0, 32'h0);
         #1;
         chk("reset_rs1", 64'(u_if.ID_rs1_out_o), 64'h0);
         chk("reset_rs2", 64'(u_if.ID_rs2_out_o), 64'h0);
      end

      tick();
      drive(32'h13, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      mdl[5] = 32'hDEADBEEF;
      drive(rtype(5'd5, 5'd0, 5'd7, 3'd0, 7'd0), 32'h100, 1'b0, 5'd0, 32'h0);
      #1;
      chk("add_rs1", 64'(u_if.ID_rs1_out_o), 64'hDEADBEEF);
      chk("add_rd", 64'(u_if.ID_rd_o), 64'd7);
      chk("add_load", 64'(u_if.ID_ctrl_word_o.load_regfile), 64'd1);
      chk("add_aluop", 64'(u_if.ID_ctrl_word_o.aluop), 64'(alu_add));

      drive(32'h13, 32'h0, 1'b1, 5'd3, 32'h11111111);
      tick();
      mdl[3] = 32'h11111111;
      drive(rtype(5'd3, 5'd0, 5'd1, 3'd0, 7'd0), 32'h104, 1'b1, 5'd3, 32'h12345678);
      #1;
      chk("bypass_same_cycle", 64'(u_if.ID_rs1_out_o),
          Bypass ? 64'h12345678 : 64'h11111111);
      tick();
      mdl[3] = 32'h12345678;
      chk("after_write_edge", 64'(u_if.ID_rs1_out_o), 64'h12345678);

      drive(32'hFE000EE3, 32'h200, 1'b0, 5'd0, 32'h0);
      #1;
      chk("beq_b_imm", 64'(u_if.ID_b_imm_o), 64'hFFFFFFFC);
      chk("beq_br_en", 64'(u_if.ID_br_en_o), 64'd1);
      chk("beq_load", 64'(u_if.ID_ctrl_word_o.load_regfile), 64'd0);

      drive(rtype(5'd0, 5'd0, 5'd1, 3'd0, 7'd0), 32'h300, 1'b1, 5'd0, 32'hFFFFFFFF);
      #1;
      chk("x0_no_bypass", 64'(u_if.ID_rs1_out_o), 64'h0);
      tick();
      chk("x0_rs1", 64'(u_if.ID_rs1_out_o), 64'h0);
      chk("x0_rs2", 64'(u_if.ID_rs2_out_o), 64'h0);

      drive(32'hABCDE07F, 32'h400, 1'b0, 5'd0, 32'h0);
      #1;
      chk("nop_ctrl", 64'(u_if.ID_ctrl_word_o), 64'h0);
      chk("nop_instr", 64'(u_if.ID_instr_o), 64'hABCDE07F);
      chk("nop_pc", 64'(u_if.ID_pc_out_o), 64'h400);
      chk("nop_br_en", 64'(u_if.ID_br_en_o), 64'd0);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] ins, pc, d, a, b;
         logic        ld;
         logic [4:0]  rdw;
         ins      = $urandom;
         ins[6:0] = ops[$urandom_range(0, 8)];
         if (ins[6:0] == 7'h63 && ins[14:13] == 2'b01) ins[14] = 1'b1;
         pc  = $urandom;
         ld  = 1'($urandom_range(0, 1));
         rdw = 5'($urandom_range(0, 31));
         d   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         drive(ins, pc, ld, rdw, d);
         #1;
         a = exp_reg(ins[19:15], ld, rdw, d);
         b = exp_reg(ins[24:20], ld, rdw, d);
         chk("rnd_rs1", 64'(u_if.ID_rs1_out_o), 64'(a));
         chk("rnd_rs2", 64'(u_if.ID_rs2_out_o), 64'(b));
         chk("rnd_i_imm", 64'(u_if.ID_i_imm_o), 64'(exp_i(ins)));
         chk("rnd_s_imm", 64'(u_if.ID_s_imm_o), 64'(exp_s(ins)));
         chk("rnd_b_imm", 64'(u_if.ID_b_imm_o), 64'(exp_b(ins)));
         chk("rnd_u_imm", 64'(u_if.ID_u_imm_o), 64'(ins & 32'hFFFFF000));
         chk("rnd_j_imm", 64'(u_if.ID_j_imm_o), 64'(exp_j(ins)));
         chk("rnd_rd", 64'(u_if.ID_rd_o), 64'(ins[11:7]));
         chk("rnd_instr", 64'(u_if.ID_instr_o), 64'(ins));
         chk("rnd_pc", 64'(u_if.ID_pc_out_o), 64'(pc));
         chk("rnd_load", 64'(u_if.ID_ctrl_word_o.load_regfile), 64'(exp_ld(ins)));
         chk("rnd_br_en", 64'(u_if.ID_br_en_o), 64'(exp_br(ins, a, b)));
         chk("rnd_mem_read", 64'(u_if.ID_ctrl_word_o.mem_read), 64'(ins[6:0] == 7'h03));
         chk("rnd_mem_write", 64'(u_if.ID_ctrl_word_o.mem_write), 64'(ins[6:0] == 7'h23));
         if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0) begin
            chk("rnd_add_sub", 64'(u_if.ID_ctrl_word_o.aluop),
                ins[30] ? 64'(alu_sub) : 64'(alu_add));
         end
         tick();
         if (ld && rdw != 5'd0) mdl[rdw] = d;
      end

      // Asynchronous clear between clock edges, then writes held off
      drive(32'h13, 32'h0, 1'b1, 5'd9, 32'hA5A5A5A5);
      tick();
      mdl[9] = 32'hA5A5A5A5;
      drive(rtype(5'd9, 5'd9, 5'd1, 3'd0, 7'd0), 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("x9_before_reset", 64'(u_if.ID_rs1_out_o), 64'hA5A5A5A5);
      rst = 1'b0;
      #1;
      chk("async_clear_x9", 64'(u_if.ID_rs1_out_o), 64'h0);
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      drive(rtype(5'd9, 5'd9, 5'd1, 3'd0, 7'd0), 32'h0, 1'b1, 5'd9, 32'h55555555);
      #1;
      chk("reset_no_bypass", 64'(u_if.ID_rs1_out_o), 64'h0);
      tick();
      chk("reset_blocks_write", 64'(u_if.ID_rs2_out_o), 64'h0);
      drive(32'h13, 32'h0, 1'b0, 5'd0, 32'h0);
      for (int r = 1; r < 32; r++) begin
         drive(rtype(5'(r), 5'd0, 5'd1, 3'd0, 7'd0), 32'h0, 1'b0, 5'd0, 32'h0);
         #1;
         chk("held_reset_rs1", 64'(u_if.ID_rs1_out_o), 64'(mdl[r]));
      end
      rst = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
